jac_sequencer: RTL and testbench
================================

# jac_sequencer

Instruction sequencer for the 8-bit Jac1-8 core. It fetches 18-bit instructions over a req/ack instruction-memory port and holds the four-entry 8-bit register file. It drives the combinational ALU_J datapath (opcode, operands, param), writes results and flags back, and executes the program-flow opcodes itself. It sits between instruction memory and the ALU as the core's only controller.

## Interface
Parameters:
- DataWidth, 8, register/ALU data width
- ParamBits, 8, param field width = PC width
- InstrWidth, 18, instruction word width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = execute; 0 = pause at next instruction boundary
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  8  fetch address (= PC)
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  18  instruction word
- alu_opcode  out  5  ALU opcode
- alu_operand1  out  8  ALU operand1
- alu_operand2  out  8  ALU operand2
- alu_param  out  8  ALU param
- alu_result  in  8  ALU result
- alu_status  in  3  ALU status; only bit 0 (carry) is used
- flag_zero  out  1  registered zero flag
- flag_carry  out  1  registered carry flag
- halted  out  1  core halted
- instr_done  out  1  one-cycle pulse per retired instruction
- dbg_sel  in  2  debug register select
- dbg_data  out  8  combinational read of r[dbg_sel]

## Operation
- Instruction fields:
  - opcode = [17:13]
  - rd = [12:11]
  - rs = [10:9]
  - [8] reserved, ignored
  - param = [7:0]
- FSM states:
  - IDLE: run=1 -> FETCH
  - FETCH: imem_req=1; imem_ack=1 -> latch imem_data, go to EXEC
  - EXEC: retire the instruction, pulse instr_done; then HALT if opcode is 11xxx, else FETCH if run=1, else IDLE
  - HALT: terminal until reset
- ALU drive in EXEC:
  - alu_opcode = opcode
  - alu_operand1 = r[rd], alu_operand2 = r[rs]
  - alu_param = param
- ALU drive in all other states: alu_opcode = 00000; operands and param remain the register-selected values.
- ALU ops 00001–01000 (ADD, SUB, AND, OR, NOT, XOR, SHL, SHR):
  - r[rd] <= alu_result, whatever the ALU returns
  - flag_carry <= alu_status[0]
  - flag_zero <= (alu_result == 0)
- VAL (01001): r[rd] <= param; flags unchanged.
- NOP and reserved 01010–01111, 10110, 10111: no register or flag change.
- Flow opcodes, comparisons unsigned on r[rd] vs r[rs]; taken -> PC <= param, else PC <= PC+1:
  - GOTO: always taken
  - IFZ: taken if flag_zero=1
  - IFNZ: taken if flag_zero=0
  - IFEQ: taken if r[rd] == r[rs]
  - IFST: taken if r[rd] < r[rs]
  - IFGT: taken if r[rd] > r[rs]
- All non-flow opcodes: PC <= PC+1, mod 256; 0xFF wraps to 0x00.
- 11xxx (load/store/IO, unimplemented): halted=1; PC, registers and flags frozen.

## Timing
- Reset values: state IDLE, PC 0x00, r0–r3 0x00, flags 0, imem_req 0, halted 0, instr_done 0.
- imem_req and imem_addr are decoded from registered state/PC. Earliest ack is the first FETCH cycle.
- Minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- imem_addr is stable while imem_req=1.
- imem_ack is ignored outside FETCH.
- run is sampled only in IDLE and at EXEC exit. Dropping run in FETCH does not abort the fetch.
- reset_n assertion mid-fetch drops imem_req asynchronously. A late ack after reset is ignored.
- dbg_data shows the new value in the cycle after the EXEC write edge.
- alu_status bits 1–2 are ignored.

## Structure
- Shared package jac_pkg holds:
  - opcode localparams, matching ALU_J encoding
  - FSM state enum
  - instruction field bit positions
- Sub-module jac_regfile: 4x8, two async read ports plus a debug read port, one synchronous write port, async active-low reset to zero.
- ALU_J is instantiated outside, beside this block.

## Test plan
- Reset, then VAL r1,0x05; VAL r2,0x03; ADD r1,r2 -> r1=0x08, carry 0, zero 0, three instr_done pulses.
- VAL r1,0xFF; VAL r2,0x01; ADD r1,r2; IFZ 0x10 -> r1=0x00, carry 1, zero 1, next imem_addr=0x10.
- Ack delayed 3 cycles -> imem_req and imem_addr held constant, no register/PC change until ack.
- r1=0x04, r2=0x09: IFST r1,r2,0x20 -> PC=0x20; IFGT r1,r2,0x30 at 0x20 -> PC=0x21.
- Opcode 11000 -> halted=1, imem_req stays 0 despite run=1; reset_n low clears halted and PC=0x00.
- NOP at PC 0xFF -> next fetch at 0x00; run=0 during EXEC -> IDLE, no req; run=1 resumes at the next PC.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 sequencer: opcode map (ALU_J encoding),
// FSM states and instruction field positions.
package jac_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_VAL  = 5'b01001;
  localparam logic [4:0] OP_GOTO = 5'b10000;
  localparam logic [4:0] OP_IFZ  = 5'b10001;
  localparam logic [4:0] OP_IFNZ = 5'b10010;
  localparam logic [4:0] OP_IFEQ = 5'b10011;
  localparam logic [4:0] OP_IFST = 5'b10100;
  localparam logic [4:0] OP_IFGT = 5'b10101;

  localparam int unsigned OPC_MSB   = 17;
  localparam int unsigned OPC_LSB   = 13;
  localparam int unsigned RD_MSB    = 12;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned RS_MSB    = 10;
  localparam int unsigned RS_LSB    = 9;
  localparam int unsigned RSVD_BIT  = 8;
  localparam int unsigned PARAM_MSB = 7;
  localparam int unsigned PARAM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // 11xxx covers the unimplemented load/store/IO group, which stops the core.
  function automatic logic is_halt_op(input logic [4:0] op);
    return op[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// Four-entry register file: two async read ports, one debug read port,
// one synchronous write port, async active-low clear.
module jac_regfile #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           i_ra_sel,
  input  logic [1:0]           i_rb_sel,
  input  logic [1:0]           i_dbg_sel,
  output logic [DataWidth-1:0] o_ra,
  output logic [DataWidth-1:0] o_rb,
  output logic [DataWidth-1:0] o_dbg,
  input  logic                 i_we,
  input  logic [1:0]           i_wsel,
  input  logic [DataWidth-1:0] i_wdata
);

  logic [DataWidth-1:0] r_regs [4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wsel] <= i_wdata;
    end
  end

  assign o_ra  = r_regs[i_ra_sel];
  assign o_rb  = r_regs[i_rb_sel];
  assign o_dbg = r_regs[i_dbg_sel];

endmodule

// File: rtl/jac_sequencer.sv
// Jac1-8 instruction sequencer: fetches over a req/ack port, drives the
// external ALU_J in EXEC, writes back results/flags and executes flow opcodes.
module jac_sequencer
  import jac_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned ParamBits  = 8,
  parameter int unsigned InstrWidth = 18
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  output logic                  imem_req,
  output logic [ParamBits-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [InstrWidth-1:0] imem_data,
  output logic [4:0]            alu_opcode,
  output logic [DataWidth-1:0]  alu_operand1,
  output logic [DataWidth-1:0]  alu_operand2,
  output logic [ParamBits-1:0]  alu_param,
  input  logic [DataWidth-1:0]  alu_result,
  input  logic [2:0]            alu_status,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  halted,
  output logic                  instr_done,
  input  logic [1:0]            dbg_sel,
  output logic [DataWidth-1:0]  dbg_data
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ParamBits-1:0]  r_pc;
  logic [InstrWidth-1:0] r_instr;
  logic                  r_flag_z;
  logic                  r_flag_c;

  logic [4:0]            w_opcode;
  logic [1:0]            w_rd;
  logic [1:0]            w_rs;
  logic [ParamBits-1:0]  w_param;
  logic [DataWidth-1:0]  w_op_a;
  logic [DataWidth-1:0]  w_op_b;
  logic                  w_exec;
  logic                  w_is_alu;
  logic                  w_is_val;
  logic                  w_is_halt;
  logic                  w_taken;
  logic                  w_we;
  logic [DataWidth-1:0]  w_wdata;
  logic                  w_unused;

  assign w_opcode  = r_instr[OPC_MSB:OPC_LSB];
  assign w_rd      = r_instr[RD_MSB:RD_LSB];
  assign w_rs      = r_instr[RS_MSB:RS_LSB];
  assign w_param   = r_instr[PARAM_MSB:PARAM_LSB];
  assign w_unused  = ^{alu_status[2:1], r_instr[RSVD_BIT]};

  assign w_exec    = (r_state == ST_EXEC);
  assign w_is_alu  = is_alu_op(w_opcode);
  assign w_is_val  = (w_opcode == OP_VAL);
  assign w_is_halt = is_halt_op(w_opcode);
  assign w_we      = w_exec && (w_is_alu || w_is_val);
  assign w_wdata   = w_is_val ? DataWidth'(w_param) : alu_result;

  jac_regfile #(
    .DataWidth (DataWidth)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_ra_sel  (w_rd),
    .i_rb_sel  (w_rs),
    .i_dbg_sel (dbg_sel),
    .o_ra      (w_op_a),
    .o_rb      (w_op_b),
    .o_dbg     (dbg_data),
    .i_we      (w_we),
    .i_wsel    (w_rd),
    .i_wdata   (w_wdata)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_opcode)
      OP_GOTO: w_taken = 1'b1;
      OP_IFZ:  w_taken = r_flag_z;
      OP_IFNZ: w_taken = !r_flag_z;
      OP_IFEQ: w_taken = (w_op_a == w_op_b);
      OP_IFST: w_taken = (w_op_a <  w_op_b);
      OP_IFGT: w_taken = (w_op_a >  w_op_b);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_is_halt)  w_state_nxt = ST_HALT;
        else if (run)   w_state_nxt = ST_FETCH;
        else            w_state_nxt = ST_IDLE;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_instr <= imem_data;
      end
      if (w_exec && !w_is_halt) begin
        r_pc <= w_taken ? w_param : r_pc + 1'b1;
      end
      if (w_exec && w_is_alu) begin
        r_flag_c <= alu_status[0];
        r_flag_z <= (alu_result == '0);
      end
    end
  end

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign alu_opcode   = w_exec ? w_opcode : OP_NOP;
  assign alu_operand1 = w_op_a;
  assign alu_operand2 = w_op_b;
  assign alu_param    = w_param;
  assign flag_zero    = r_flag_z;
  assign flag_carry   = r_flag_c;
  assign halted       = (r_state == ST_HALT);
  assign instr_done   = w_exec;

endmodule

// File: tb/tb_jac_sequencer.sv
// Directed bench for jac_sequencer with a behavioural ALU_J and a
// wait-state-programmable instruction memory.
module tb_jac_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [17:0] imem_data = '0;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [7:0]  alu_param;
  logic [7:0]  alu_result;
  logic [2:0]  alu_status;
  logic        flag_zero;
  logic        flag_carry;
  logic        halted;
  logic        instr_done;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;
  int done_total = 0;
  int wait_cycles = 0;
  int wait_cnt = 0;
  logic [17:0] mem [256];
  logic        alu_c;

  jac_sequencer #(
    .DataWidth  (8),
    .ParamBits  (8),
    .InstrWidth (18)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_param    (alu_param),
    .alu_result   (alu_result),
    .alu_status   (alu_status),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .halted       (halted),
    .instr_done   (instr_done),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  always #5 clock = ~clock;

  // ALU_J model; status bits 1-2 are driven high so the core must ignore them.
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    case (alu_opcode)
      5'd1: {alu_c, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      5'd2: begin alu_result = alu_operand1 - alu_operand2; alu_c = alu_operand1 < alu_operand2; end
      5'd3: alu_result = alu_operand1 & alu_operand2;
      5'd4: alu_result = alu_operand1 | alu_operand2;
      5'd5: alu_result = ~alu_operand1;
      5'd6: alu_result = alu_operand1 ^ alu_operand2;
      5'd7: {alu_c, alu_result} = {alu_operand1, 1'b0};
      5'd8: begin alu_result = alu_operand1 >> 1; alu_c = alu_operand1[0]; end
      default: ;
    endcase
    alu_status = {2'b11, alu_c};
  end

  always @(negedge clock) begin
    if (imem_req && wait_cnt >= wait_cycles) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
      wait_cnt  = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wait_cnt = wait_cnt + 1;
      else          wait_cnt = 0;
    end
  end

  always @(posedge clock) begin
    if (instr_done) done_total <= done_total + 1;
  end

  function automatic logic [17:0] enc(input logic [4:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] p);
    return {op, rd, rs, 1'b0, p};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc(5'b11000, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    run = 1'b0;
    wait_cycles = 0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 400) begin cyc(); n++; end
    checks++;
    if (!halted) begin errors++; $display("FAIL %s: halted=%0b required 1 (timeout)", name, halted); end
  endtask

  task automatic wait_fetch(input string name);
    int n = 0;
    while (!imem_req && n < 100) begin cyc(); n++; end
    checks++;
    if (!imem_req) begin errors++; $display("FAIL %s: imem_req=%0b required 1 (timeout)", name, imem_req); end
  endtask

  task automatic test_reset();
    logic [7:0] exp_zero;
    exp_zero = 8'h00;
    clear_mem();
    do_reset();
    #1;
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", instr_done); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {flag_zero, flag_carry}); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++; if (dbg_data !== exp_zero) begin errors++; $display("FAIL rst_r%0d: got %h want 00", i, dbg_data); end
    end
    // Reset asserted mid-fetch must drop imem_req without waiting for a clock edge.
    wait_cycles = 10;
    run = 1'b1;
    wait_fetch("midfetch_req");
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_drop: got %0b want 0", imem_req); end
    run = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_idle: got %0b want 0", imem_req); end
  endtask

  task automatic test_add();
    int d0;
    clear_mem();
    mem[0] = enc(5'b01001, 2'd1, 2'd0, 8'h05);
    mem[1] = enc(5'b01001, 2'd2, 2'd0, 8'h03);
    mem[2] = enc(5'b00001, 2'd1, 2'd2, 8'h00);
    do_reset();
    d0 = done_total;
    run = 1'b1;
    wait_halt("add_halt");
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 8'h08) begin errors++; $display("FAIL add_r1: got %h want 08", dbg_data); end
    checks++; if (flag_carry !== 1'b0) begin errors++; $display("FAIL add_carry: got %0b want 0", flag_carry); end
    checks++; if (flag_zero !== 1'b0)  begin errors++; $display("FAIL add_zero: got %0b want 0", flag_zero); end
    // three program instructions plus the halting 11000 at address 3
    checks++; if (done_total - d0 !== 4) begin errors++; $display("FAIL add_done: got %0d want 4", done_total - d0); end
    checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL add_pc: got %h want 03", imem_addr); end
  endtask

  task automatic test_carry_ifz();
    clear_mem();
    mem[0] = enc(5'b01001, 2'd1, 2'd0, 8'hFF);
    mem[1] = enc(5'b01001, 2'd2, 2'd0, 8'h01);
    mem[2] = enc(5'b00001, 2'd1, 2'd2, 8'h00);
    mem[3] = enc(5'b10001, 2'd0, 2'd0, 8'h10);
    do_reset();
    run = 1'b1;
    wait_halt("ifz_halt");
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 8'h00)  begin errors++; $display("FAIL ifz_r1: got %h want 00", dbg_data); end
    checks++; if (flag_carry !== 1'b1) begin errors++; $display("FAIL ifz_carry: got %0b want 1", flag_carry); end
    checks++; if (flag_zero !== 1'b1)  begin errors++; $display("FAIL ifz_zero: got %0b want 1", flag_zero); end
    checks++; if (imem_addr !== 8'h10) begin errors++; $display("FAIL ifz_target: got %h want 10", imem_addr); end
  endtask

  task automatic test_delayed_ack();
    clear_mem();
    mem[0] = enc(5'b01001, 2'd0, 2'd0, 8'h5A);
    do_reset();
    wait_cycles = 3;
    dbg_sel = 2'd0;
    run = 1'b1;
    wait_fetch("dly_req");
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL dly_hold_req%0d: got %0b want 1", i, imem_req); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL dly_hold_addr%0d: got %h want 00", i, imem_addr); end
      checks++; if (dbg_data !== 8'h00)  begin errors++; $display("FAIL dly_hold_r0_%0d: got %h want 00", i, dbg_data); end
      run = 1'b0;
      cyc();
    end
    run = 1'b1;
    wait_halt("dly_halt");
    checks++; if (dbg_data !== 8'h5A)  begin errors++; $display("FAIL dly_r0: got %h want 5a", dbg_data); end
    checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL dly_pc: got %h want 01", imem_addr); end
  endtask

  task automatic test_compare();
    clear_mem();
    mem[0]    = enc(5'b01001, 2'd1, 2'd0, 8'h04);
    mem[1]    = enc(5'b01001, 2'd2, 2'd0, 8'h09);
    mem[2]    = enc(5'b10100, 2'd1, 2'd2, 8'h20);
    mem[8'h20] = enc(5'b10101, 2'd1, 2'd2, 8'h30);
    do_reset();
    run = 1'b1;
    wait_halt("cmp_halt");
    checks++; if (imem_addr !== 8'h21) begin errors++; $display("FAIL cmp_pc: got %h want 21", imem_addr); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL cmp_flags: got %b want 00", {flag_zero, flag_carry}); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = enc(5'b01001, 2'd3, 2'd0, 8'h77);
    mem[1] = enc(5'b11111, 2'd3, 2'd3, 8'h00);
    do_reset();
    dbg_sel = 2'd3;
    run = 1'b1;
    wait_halt("hlt_halt");
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_req%0d: got %0b want 0", i, imem_req); end
      checks++; if (halted !== 1'b1)   begin errors++; $display("FAIL hlt_stay%0d: got %0b want 1", i, halted); end
    end
    checks++; if (dbg_data !== 8'h77)  begin errors++; $display("FAIL hlt_r3: got %h want 77", dbg_data); end
    checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL hlt_pc: got %h want 01", imem_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL hlt_rst: got %0b want 0", halted); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL hlt_rst_pc: got %h want 00", imem_addr); end
    checks++; if (dbg_data !== 8'h00)  begin errors++; $display("FAIL hlt_rst_r3: got %h want 00", dbg_data); end
    run = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_wrap_pause();
    int d0;
    int n;
    clear_mem();
    mem[0]     = enc(5'b10000, 2'd0, 2'd0, 8'hFF);
    mem[8'hFF] = enc(5'b00000, 2'd0, 2'd0, 8'h00);
    do_reset();
    run = 1'b1;
    cyc();
    wait_fetch("wrap_f0");
    cyc();
    wait_fetch("wrap_fff");
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_goto: got %h want ff", imem_addr); end
    cyc();
    wait_fetch("wrap_f00");
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", imem_addr); end
    n = 0;
    while (!instr_done && n < 20) begin cyc(); n++; end
    run = 1'b0;
    d0 = done_total;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pause_req%0d: got %0b want 0", i, imem_req); end
    end
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL pause_done: got %0d want 1", done_total - d0); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL pause_halted: got %0b want 0", halted); end
    run = 1'b1;
    wait_fetch("resume_req");
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL resume_pc: got %h want ff", imem_addr); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ifz();
    test_delayed_ack();
    test_compare();
    test_halt();
    test_wrap_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
